// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit feeder.
// The feeder FSM state type and the default data width live here so that the FIFO and the feeder agree on them.
package uart_tx_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    // Busy appears 2 cycles after Data_Valid, so the acknowledge window needs at least 3 cycles.
    localparam int ACK_TIMEOUT_MIN = 3;

    typedef enum logic [1:0] {
        F_IDLE      = 2'd0,
        F_ISSUE     = 2'd1,
        F_WAIT_ACK  = 2'd2,
        F_WAIT_DONE = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with first-word-fall-through read data.
// The flags are registered from the next occupancy, so full, empty and level update on the same edge.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int DEPTH      = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic [AW:0]           count_nxt;
    logic                  do_wr;
    logic                  do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    always_comb begin
        count_nxt = count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end

    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds queued bytes to the UART transmit FSM one frame at a time and flags overflow or a missing acknowledge.
// state       | meaning
// F_IDLE      | waiting for a queued byte
// F_ISSUE     | pop the head, pulse Data_Valid, latch P_DATA
// F_WAIT_ACK  | waiting up to ACK_TIMEOUT cycles for Busy to rise
// F_WAIT_DONE | frame in flight, waiting for Busy to fall
module uart_tx_feeder
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     Busy,
    output logic                     Data_Valid,
    output logic [DATA_WIDTH-1:0]    P_DATA,
    output logic                     ovf_err,
    output logic                     ack_err,
    input  logic                     err_clr
);

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] ACK_TC = CW'(ACK_TIMEOUT - 1);

    if (ACK_TIMEOUT < ACK_TIMEOUT_MIN || DEPTH < 2) begin : g_bad_params
        $error("uart_tx_feeder: ACK_TIMEOUT or DEPTH below minimum");
    end

    feeder_state_t         state;
    logic [CW-1:0]         ack_cnt;
    logic [DATA_WIDTH-1:0] head;
    logic                  pop;
    logic                  ack_set;
    logic                  ovf_set;

    assign pop     = (state == F_ISSUE) && !empty;
    assign ack_set = (state == F_WAIT_ACK) && !Busy && (ack_cnt == ACK_TC);
    assign ovf_set = wr_en && full;

    uart_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= F_IDLE;
            Data_Valid <= 1'b0;
            P_DATA     <= '0;
            ack_cnt    <= '0;
        end else begin
            Data_Valid <= 1'b0;
            case (state)
                F_IDLE: begin
                    if (!empty) begin
                        state <= F_ISSUE;
                    end
                end
                F_ISSUE: begin
                    if (!empty) begin
                        Data_Valid <= 1'b1;
                        P_DATA     <= head;
                        ack_cnt    <= '0;
                        state      <= F_WAIT_ACK;
                    end else begin
                        state <= F_IDLE;
                    end
                end
                F_WAIT_ACK: begin
                    if (Busy) begin
                        state <= F_WAIT_DONE;
                    end else if (ack_cnt == ACK_TC) begin
                        state <= F_IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                F_WAIT_DONE: begin
                    if (!Busy) begin
                        state <= F_IDLE;
                    end
                end
                default: state <= F_IDLE;
            endcase
        end
    end

    // A set condition in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_err <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            ovf_err <= ovf_set || (ovf_err && !err_clr);
            ack_err <= ack_set || (ack_err && !err_clr);
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed and random checks of uart_tx_feeder against a queue-based scoreboard and a simple transmitter model.
module tb_uart_tx_feeder;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AT    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          Busy;
    logic          Data_Valid;
    logic [DW-1:0] P_DATA;
    logic          ovf_err;
    logic          ack_err;
    logic          err_clr;

    uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ACK_TIMEOUT(AT)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .Busy       (Busy),
        .Data_Valid (Data_Valid),
        .P_DATA     (P_DATA),
        .ovf_err    (ovf_err),
        .ack_err    (ack_err),
        .err_clr    (err_clr)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    byte unsigned q[$];
    int           m_count;
    logic         m_ovf;
    logic         m_ack;
    logic [DW-1:0] m_pd;
    int           tick_no;
    int           dv_count;
    int           last_dv_tick;
    int           first_ack_tick;
    int           fall_edge;
    logic         prev_busy;
    int           ack_pend;
    int           ack_win;
    logic         ack_seen;
    // transmitter model: 0 = responds to Data_Valid, 1 = Busy held high, 2 = Busy tied low
    int           tx_mode;
    int           rise_cd;
    int           frame_cd;
    int           frame_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_count   = 0;
        m_ovf     = 1'b0;
        m_ack     = 1'b0;
        m_pd      = '0;
        ack_pend  = 0;
        ack_win   = 0;
        ack_seen  = 1'b0;
        fall_edge = -100;
        prev_busy = 1'b0;
        rise_cd   = 0;
        frame_cd  = 0;
        Busy      = 1'b0;
    endtask

    task automatic tick();
        logic          e_wr, e_rst, e_clr, e_busy, acc, ovf_set, ack_set;
        logic [DW-1:0] e_data;
        byte unsigned  front;
        e_wr   = wr_en;
        e_rst  = RST;
        e_clr  = err_clr;
        e_busy = Busy;
        e_data = wr_data;
        @(posedge CLK);
        #1;
        tick_no++;
        if (e_rst) begin
            model_reset();
            check("rst_dv", Data_Valid, 0);
            check("rst_level", level, 0);
            check("rst_empty", empty, 1);
            check("rst_full", full, 0);
            check("rst_pdata", P_DATA, 0);
            check("rst_errs", {ovf_err, ack_err}, 0);
            return;
        end
        if (!e_busy && prev_busy) fall_edge = tick_no;
        prev_busy = e_busy;

        ack_set = 1'b0;
        if (ack_pend != 0) begin
            ack_seen = ack_seen | e_busy;
            ack_win--;
            if (ack_win == 0) begin
                ack_pend = 0;
                if (!ack_seen) ack_set = 1'b1;
            end
        end
        ovf_set = e_wr && (m_count == DEPTH);
        acc     = e_wr && (m_count < DEPTH);

        // transmitter steps first so a fresh Data_Valid starts its own 2-cycle delay
        case (tx_mode)
            1: Busy = 1'b1;
            2: Busy = 1'b0;
            default: begin
                if (rise_cd > 0) begin
                    rise_cd--;
                    if (rise_cd == 0) begin
                        Busy     = 1'b1;
                        frame_cd = frame_len;
                    end
                end else if (Busy && frame_cd > 0) begin
                    frame_cd--;
                    if (frame_cd == 0) Busy = 1'b0;
                end
            end
        endcase

        if (Data_Valid) begin
            dv_count++;
            last_dv_tick = tick_no;
            if (q.size() == 0) begin
                check("dv_when_empty", Data_Valid, 0);
            end else begin
                front = q.pop_front();
                m_pd  = front;
                m_count--;
            end
            if (tx_mode == 0) begin
                check("dv_while_busy", e_busy, 0);
                check("dv_gap_after_busy_ok", (tick_no - fall_edge) >= 2, 1);
                rise_cd = 2;
            end
            ack_pend = 1;
            ack_win  = AT;
            ack_seen = 1'b0;
        end
        if (acc) begin
            q.push_back(e_data);
            m_count++;
        end
        m_ovf = ovf_set | (m_ovf & ~e_clr);
        m_ack = ack_set | (m_ack & ~e_clr);
        if (ack_err && first_ack_tick < 0) first_ack_tick = tick_no;

        check("level", level, m_count);
        check("full", full, m_count == DEPTH);
        check("empty", empty, m_count == 0);
        check("p_data", P_DATA, m_pd);
        check("ovf_err", ovf_err, m_ovf);
        check("ack_err", ack_err, m_ack);
    endtask

    task automatic write_byte(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        int dv0, wr_tick;
        RST = 1'b1; wr_en = 1'b0; wr_data = '0; err_clr = 1'b0;
        tick_no = 0; dv_count = 0; last_dv_tick = -1; first_ack_tick = -1;
        tx_mode = 0; frame_len = 5;
        model_reset();
        repeat (3) tick();
        RST = 1'b0;
        repeat (2) tick();

        // single byte, exact issue latency
        dv0 = dv_count;
        write_byte(8'hA5);
        wr_tick = tick_no;
        repeat (11) tick();
        check("t1_dv_count", dv_count - dv0, 1);
        check("t1_latency", last_dv_tick - wr_tick, 2);
        check("t1_pdata", P_DATA, 8'hA5);
        check("t1_level", level, 0);

        // three back-to-back bytes
        dv0 = dv_count;
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        repeat (60) tick();
        check("t2_dv_count", dv_count - dv0, 3);
        check("t2_pdata_last", P_DATA, 8'h33);

        // fill with the transmitter stalled, then overflow
        tx_mode = 1; Busy = 1'b1;
        dv0 = dv_count;
        for (int i = 0; i < 9; i++) write_byte(8'h40 + 8'(i));
        write_byte(8'hFF);
        repeat (3) tick();
        check("t3_full", full, 1);
        check("t3_level", level, DEPTH);
        check("t3_ovf", ovf_err, 1);
        wr_en = 1'b1; wr_data = 8'hFF; err_clr = 1'b1;
        tick();
        wr_en = 1'b0; err_clr = 1'b0;
        check("t3_ovf_set_wins", ovf_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_ovf_cleared", ovf_err, 0);
        tx_mode = 0; Busy = 1'b0; rise_cd = 0; frame_cd = 0; frame_len = 4;
        repeat (130) tick();
        check("t3_drain_level", level, 0);
        check("t3_dv_count", dv_count - dv0, 9);
        check("t3_last_pdata", P_DATA, 8'h48);

        // transmitter never acknowledges
        tx_mode = 2; Busy = 1'b0; first_ack_tick = -1;
        dv0 = dv_count;
        write_byte(8'h5A);
        repeat (10) tick();
        check("t4_dv_count", dv_count - dv0, 1);
        check("t4_ack_delay", first_ack_tick - last_dv_tick, AT);
        check("t4_ack", ack_err, 1);
        check("t4_level", level, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_ack_cleared", ack_err, 0);
        tx_mode = 0;
        repeat (3) tick();

        // reset while a long frame is in flight with words queued
        frame_len = 25;
        write_byte(8'hC1); write_byte(8'hC2); write_byte(8'hC3); write_byte(8'hC4);
        repeat (8) tick();
        check("t5_level_before", level, 3);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t5_empty", empty, 1);
        check("t5_level", level, 0);
        check("t5_dv", Data_Valid, 0);
        check("t5_pdata", P_DATA, 0);
        dv0 = dv_count;
        repeat (20) tick();
        check("t5_no_pulses", dv_count - dv0, 0);

        // write coinciding with a pop at level 1, then pointer wrap
        frame_len = 4;
        write_byte(8'hD1);
        tick();
        dv0 = dv_count;
        write_byte(8'hD2);
        check("t6_pop_edge_dv", Data_Valid, 1);
        check("t6_level_wr_pop", level, 1);
        repeat (30) tick();
        check("t6_dv_count", dv_count - dv0, 2);
        dv0 = dv_count;
        for (int i = 0; i < 12; i++) begin
            write_byte(8'($urandom));
            repeat (12) tick();
        end
        check("t6_wrap_dv_count", dv_count - dv0, 12);
        check("t6_wrap_level", level, 0);

        // random traffic with a variable-length transmitter
        for (int i = 0; i < 400; i++) begin
            wr_en     = ($urandom_range(0, 99) < 35);
            wr_data   = 8'($urandom);
            err_clr   = ($urandom_range(0, 49) == 0);
            frame_len = $urandom_range(2, 8);
            tick();
        end
        wr_en = 1'b0; err_clr = 1'b0;
        repeat (150) tick();
        check("t7_drain_level", level, 0);
        check("t7_ack_clear", ack_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
